// File: rtl/frontend_response_dispatcher_if.sv
// Completion return channel: backend push side plus the shared per-core delivery bus.
// The dispatcher takes the slave modport; the backend/core-side agent takes master.
interface frontend_response_dispatcher_if #(
    parameter int DATA_BITS = 64
);
    logic                 be_valid;
    logic                 be_ready;
    logic                 be_op;
    logic [4:0]           be_req_id;
    logic [1:0]           be_core_num;
    logic [DATA_BITS-1:0] be_data;
    logic [3:0]           core_valid;
    logic [3:0]           core_ready;
    logic                 core_op;
    logic [4:0]           core_req_id;
    logic [DATA_BITS-1:0] core_data;
    logic [63:0]          resp_cnt;
    logic                 empty;

    modport slave (
        input  be_valid, be_op, be_req_id, be_core_num, be_data, core_ready,
        output be_ready, core_valid, core_op, core_req_id, core_data, resp_cnt, empty
    );

    modport master (
        output be_valid, be_op, be_req_id, be_core_num, be_data, core_ready,
        input  be_ready, core_valid, core_op, core_req_id, core_data, resp_cnt, empty
    );
endinterface

// File: rtl/frontend_response_dispatcher.sv
// In-order completion buffer: accepts tagged backend completions and hands each one
// to its destination core over a one-hot valid/ready channel, head-of-line blocking.
module frontend_response_dispatcher #(
    parameter int DATA_BITS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    frontend_response_dispatcher_if.slave bus
);
    localparam int NUM_CORES = 4;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic                 r_op_mem   [FIFO_DEPTH];
    logic [4:0]           r_id_mem   [FIFO_DEPTH];
    logic [1:0]           r_core_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] r_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W:0]              r_count;
    logic [NUM_CORES-1:0][15:0]  r_resp_cnt;

    logic                 w_nonempty;
    logic                 w_be_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_head_core;
    logic [NUM_CORES-1:0] w_core_valid;

    // Everything the cores see is decoded from registered state only.
    assign w_nonempty   = (r_count != '0);
    assign w_be_ready   = (r_count != FULL_CNT);
    assign w_push       = bus.be_valid && w_be_ready;
    assign w_head_core  = r_core_mem[r_rd_ptr];
    assign w_core_valid = w_nonempty ? (NUM_CORES'(1) << w_head_core) : '0;
    assign w_pop        = |(w_core_valid & bus.core_ready);

    assign bus.be_ready    = w_be_ready;
    assign bus.core_valid  = w_core_valid;
    assign bus.core_op     = w_nonempty & r_op_mem[r_rd_ptr];
    assign bus.core_req_id = w_nonempty ? r_id_mem[r_rd_ptr] : '0;
    assign bus.core_data   = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
    assign bus.resp_cnt    = r_resp_cnt;
    assign bus.empty       = !w_nonempty;

    // Entry storage is only ever read behind a nonzero count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]   <= bus.be_op;
            r_id_mem[r_wr_ptr]   <= bus.be_req_id;
            r_core_mem[r_wr_ptr] <= bus.be_core_num;
            r_data_mem[r_wr_ptr] <= bus.be_op ? bus.be_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_resp_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr                <= r_rd_ptr + PTR_W'(1);
                r_resp_cnt[w_head_core] <= r_resp_cnt[w_head_core] + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_frontend_response_dispatcher.sv
// Directed bench for frontend_response_dispatcher: a vector table for the
// reset/single/full/head-of-line/write-ack flow plus streaming and counter-wrap sequences.
module tb_frontend_response_dispatcher;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    frontend_response_dispatcher_if #(.DATA_BITS(64)) bus();

    frontend_response_dispatcher #(
        .DATA_BITS (64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        bv;
        logic        op;
        logic [4:0]  id;
        logic [1:0]  core;
        logic [63:0] data;
        logic [3:0]  cr;
        logic        chk;
        logic        e_rdy;
        logic [3:0]  e_cv;
        logic        e_op;
        logic [4:0]  e_id;
        logic [63:0] e_data;
        logic        e_empty;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic bv, input logic op, input logic [4:0] id,
                       input logic [1:0] c, input logic [63:0] d, input logic [3:0] cr,
                       input logic chk, input logic erdy, input logic [3:0] ecv,
                       input logic eop, input logic [4:0] eid, input logic [63:0] ed,
                       input logic eempty, input logic [63:0] ecnt);
        vec_t v;
        v = '{r, bv, op, id, c, d, cr, chk, erdy, ecv, eop, eid, ed, eempty, ecnt};
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic bv, input logic op, input logic [4:0] id,
                         input logic [1:0] c, input logic [63:0] d, input logic [3:0] cr);
        rst             = r;
        bus.be_valid    = bv;
        bus.be_op       = op;
        bus.be_req_id   = id;
        bus.be_core_num = c;
        bus.be_data     = d;
        bus.core_ready  = cr;
    endtask

    task automatic do_reset();
        repeat (2) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 64'd0, 4'h0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 64'd0, 4'h0);
    endtask

    localparam logic [63:0] DB  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] C1  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [4:0] id_q[$];
        logic [1:0] core_q[$];
        logic [4:0] nid;
        logic [1:0] ncore;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b1, 1'b1, 5'h1F, 2'd1, 64'h99, 4'h0);

        //   rst bv op id     c  data     cr     chk rdy cv     op id     data     emp cnt
        add(1, 1, 1, 5'h1F, 1, 64'h99, 4'h0, 0, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0);
        add(1, 1, 1, 5'h1F, 1, 64'h99, 4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0);
        add(0, 1, 1, 5'h0A, 2, DB,     4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h4, 1, 1, 4'h4, 1, 5'h0A, DB,     0, 64'h0);
        add(0, 1, 1, 5'h01, 0, 64'h11, 4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, C1);
        add(0, 1, 1, 5'h02, 1, 64'h22, 4'h0, 1, 1, 4'h1, 1, 5'h01, 64'h11, 0, C1);
        add(0, 1, 1, 5'h03, 2, 64'h33, 4'h0, 1, 1, 4'h1, 1, 5'h01, 64'h11, 0, C1);
        add(0, 1, 1, 5'h04, 3, 64'h44, 4'h0, 1, 1, 4'h1, 1, 5'h01, 64'h11, 0, C1);
        add(0, 1, 1, 5'h05, 0, 64'h55, 4'h0, 1, 0, 4'h1, 1, 5'h01, 64'h11, 0, C1);
        add(0, 1, 1, 5'h05, 0, 64'h55, 4'hF, 1, 0, 4'h1, 1, 5'h01, 64'h11, 0, C1);
        add(0, 1, 1, 5'h05, 0, 64'h55, 4'hF, 1, 1, 4'h2, 1, 5'h02, 64'h22, 0, 64'h0000_0001_0000_0001);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'hF, 1, 1, 4'h4, 1, 5'h03, 64'h33, 0, 64'h0000_0001_0001_0001);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'hF, 1, 1, 4'h8, 1, 5'h04, 64'h44, 0, 64'h0000_0002_0001_0001);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'hF, 1, 1, 4'h1, 1, 5'h05, 64'h55, 0, 64'h0001_0002_0001_0001);
        add(0, 1, 1, 5'h06, 1, 64'h66, 4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0001_0002_0001_0002);
        add(0, 1, 1, 5'h07, 0, 64'h77, 4'h1, 1, 1, 4'h2, 1, 5'h06, 64'h66, 0, 64'h0001_0002_0001_0002);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h1, 1, 1, 4'h2, 1, 5'h06, 64'h66, 0, 64'h0001_0002_0001_0002);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h3, 1, 1, 4'h2, 1, 5'h06, 64'h66, 0, 64'h0001_0002_0001_0002);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h3, 1, 1, 4'h1, 1, 5'h07, 64'h77, 0, 64'h0001_0002_0002_0002);
        add(0, 1, 0, 5'h1F, 3, ALL,    4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0001_0002_0002_0003);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h8, 1, 1, 4'h8, 0, 5'h1F, 64'h0,  0, 64'h0001_0002_0002_0003);
        add(0, 1, 1, 5'h08, 0, 64'h88, 4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0002_0002_0002_0003);
        add(1, 0, 0, 5'h00, 0, 64'h0,  4'h0, 1, 1, 4'h1, 1, 5'h08, 64'h88, 0, 64'h0002_0002_0002_0003);
        add(0, 0, 0, 5'h00, 0, 64'h0,  4'h0, 1, 1, 4'h0, 0, 5'h00, 64'h0,  1, 64'h0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].bv, vt[i].op, vt[i].id, vt[i].core, vt[i].data, vt[i].cr);
            #1;
            if (vt[i].chk) begin
                check($sformatf("v%0d be_ready", i),  64'(bus.be_ready),    64'(vt[i].e_rdy));
                check($sformatf("v%0d core_valid", i), 64'(bus.core_valid), 64'(vt[i].e_cv));
                check($sformatf("v%0d core_op", i),   64'(bus.core_op),     64'(vt[i].e_op));
                check($sformatf("v%0d core_req_id", i), 64'(bus.core_req_id), 64'(vt[i].e_id));
                check($sformatf("v%0d core_data", i), bus.core_data,        vt[i].e_data);
                check($sformatf("v%0d empty", i),     64'(bus.empty),       64'(vt[i].e_empty));
                check($sformatf("v%0d resp_cnt", i),  bus.resp_cnt,         vt[i].e_cnt);
            end
        end

        // Streaming at occupancy 2: push and pop every cycle, pointers wrap twice.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nid   = 5'(5'h10 + i);
            ncore = 2'(i);
            drive(1'b0, 1'b1, 1'b1, nid, ncore, 64'(nid), 4'h0);
            id_q.push_back(nid);
            core_q.push_back(ncore);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nid   = 5'(5'h12 + i);
            ncore = 2'(i);
            drive(1'b0, (i < 8), 1'b1, nid, ncore, 64'(nid), 4'hF);
            #1;
            check($sformatf("pp%0d id", i), 64'(bus.core_req_id), 64'(id_q[0]));
            check($sformatf("pp%0d valid", i), 64'(bus.core_valid), 64'(4'b0001 << core_q[0]));
            if (i < 8) check($sformatf("pp%0d be_ready", i), 64'(bus.be_ready), 64'd1);
            void'(id_q.pop_front());
            void'(core_q.pop_front());
            if (i < 8) begin
                id_q.push_back(nid);
                core_q.push_back(ncore);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 64'd0, 4'h0);
        #1;
        check("pp drained empty", 64'(bus.empty), 64'd1);

        // Continuous push/pop to core 3 until its delivery counter wraps.
        do_reset();
        for (int i = 0; i <= 65537; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 5'(i), 2'd3, 64'(i), 4'h8);
            #1;
            if (i == 65536) check("wrap cnt3 ffff", 64'(bus.resp_cnt[63:48]), 64'hFFFF);
            if (i == 65537) begin
                check("wrap cnt3 zero", 64'(bus.resp_cnt[63:48]), 64'h0);
                check("wrap other cnts", 64'(bus.resp_cnt[47:0]), 64'h0);
                check("wrap valid", 64'(bus.core_valid), 64'h8);
                check("wrap be_ready", 64'(bus.be_ready), 64'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
